lct_ghost_filter: RTL and testbench

LCT_GHOST_FILTER -- requirements
Module: lct_ghost_filter

---
 rtl/lct_ghost_filter.sv | 167 ++++++++++++++++
 tb/tb_lct_ghost_filter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lct_ghost_filter.sv
// lct_ghost_filter
// Removes ghost tracks from the two-track pattern-finder output. A track is a
// ghost if a track with an adjacent key (|dkey| <= 1) was accepted within the
// last dead_time BX with equal or better quality, or, for the second track,
// if it sits next to the best track in the same BX. Two-stage pipeline: stage 1
// registers the raw tracks, stage 2 filters, promotes and registers outputs.
//
// Ports
//   clk, rst_n               trigger clock, async active-low reset
//   hv/hp/hnp/hfap           best track in: valid, quality[1:0], key[6:0], accel flag
//   lv/lp/lnp/lfap           second track in, same fields
//   filter_en                0 = pass-through, 1 = ghost filtering
//   dead_time[2:0]           cross-BX ghost window in BX (0 disables it)
//   trig_stop                freeze: outputs zeroed, history and counters hold
//   bv/bq/bkey/bfa           filtered best track out
//   sv/sq/skey/sfa           filtered second track out
//   lct_cnt, ghost_cnt       saturating counts of emitted / suppressed tracks
module lct_ghost_filter #(
    parameter int HIST_DEPTH = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hv,
    input  logic [1:0]  hp,
    input  logic [6:0]  hnp,
    input  logic        hfap,
    input  logic        lv,
    input  logic [1:0]  lp,
    input  logic [6:0]  lnp,
    input  logic        lfap,
    input  logic        filter_en,
    input  logic [2:0]  dead_time,
    input  logic        trig_stop,
    output logic        bv,
    output logic [1:0]  bq,
    output logic [6:0]  bkey,
    output logic        bfa,
    output logic        sv,
    output logic [1:0]  sq,
    output logic [6:0]  skey,
    output logic        sfa,
    output logic [15:0] lct_cnt,
    output logic [15:0] ghost_cnt
);

    // Track word layout: {valid, quality[1:0], key[6:0], fa}. History keeps
    // only the upper ten bits because the accel flag plays no part in matching.

    // Keys match when they differ by at most one; no wrap-around.
    function automatic logic key_match(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] diff;
        diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
        return (diff <= 8'd1);
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [10:0] s1_b_r;
    logic [10:0] s1_s_r;
    logic [9:0]  hist_r [HIST_DEPTH][2];

    logic        b_hit_s;
    logic        s_hit_s;
    logic        b_sup_s;
    logic        s_sup_s;
    logic        b_keep_s;
    logic        s_keep_s;
    logic [10:0] nb_s;
    logic [10:0] ns_s;
    logic [1:0]  emit_n_s;
    logic [1:0]  ghost_n_s;

    // Stage 1: capture raw tracks every clk, even while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_b_r <= 11'd0;
            s1_s_r <= 11'd0;
        end else begin
            s1_b_r <= {hv, hp, hnp, hfap};
            s1_s_r <= {lv, lp, lnp, lfap};
        end
    end

    // Cross-BX search: any live history entry inside the window with an
    // adjacent key and quality at least as good marks the track as a ghost.
    always_comb begin
        b_hit_s = 1'b0;
        s_hit_s = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            for (int j = 0; j < 2; j++) begin
                b_hit_s = b_hit_s | (hist_r[i][j][9] && (i < int'({29'd0, dead_time}))
                                     && key_match(hist_r[i][j][6:0], s1_b_r[7:1])
                                     && (hist_r[i][j][8:7] >= s1_b_r[9:8]));
                s_hit_s = s_hit_s | (hist_r[i][j][9] && (i < int'({29'd0, dead_time}))
                                     && key_match(hist_r[i][j][6:0], s1_s_r[7:1])
                                     && (hist_r[i][j][8:7] >= s1_s_r[9:8]));
            end
        end
    end

    // Suppression decisions. The second track is compared with the original
    // best even when the best itself turns out to be a ghost.
    always_comb begin
        b_sup_s   = filter_en & s1_b_r[10] & b_hit_s;
        s_sup_s   = filter_en & s1_s_r[10]
                    & (s_hit_s | (s1_b_r[10] & key_match(s1_b_r[7:1], s1_s_r[7:1])));
        b_keep_s  = s1_b_r[10] & ~b_sup_s;
        s_keep_s  = s1_s_r[10] & ~s_sup_s;
        ghost_n_s = {1'b0, b_sup_s} + {1'b0, s_sup_s};
    end

    // Slot assignment: promote a surviving second track into an empty best
    // slot only while filtering; every unused slot is all-zero.
    always_comb begin
        nb_s = 11'd0;
        ns_s = 11'd0;
        if (b_keep_s) begin
            nb_s = s1_b_r;
            ns_s = s_keep_s ? s1_s_r : 11'd0;
        end else if (s_keep_s && filter_en) begin
            nb_s = s1_s_r;
            ns_s = 11'd0;
        end else if (s_keep_s) begin
            nb_s = 11'd0;
            ns_s = s1_s_r;
        end else begin
            nb_s = 11'd0;
            ns_s = 11'd0;
        end
        emit_n_s = {1'b0, nb_s[10]} + {1'b0, ns_s[10]};
    end

    // Stage 2: register outputs, shift history and update counters; a freeze
    // blanks the outputs and holds all state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {bv, bq, bkey, bfa} <= 11'd0;
            {sv, sq, skey, sfa} <= 11'd0;
            lct_cnt             <= 16'd0;
            ghost_cnt           <= 16'd0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_r[i][0] <= 10'd0;
                hist_r[i][1] <= 10'd0;
            end
        end else if (trig_stop) begin
            {bv, bq, bkey, bfa} <= 11'd0;
            {sv, sq, skey, sfa} <= 11'd0;
        end else begin
            {bv, bq, bkey, bfa} <= nb_s;
            {sv, sq, skey, sfa} <= ns_s;
            lct_cnt             <= sat_add(lct_cnt, emit_n_s);
            ghost_cnt           <= sat_add(ghost_cnt, ghost_n_s);
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                hist_r[i][0] <= hist_r[i-1][0];
                hist_r[i][1] <= hist_r[i-1][1];
            end
            hist_r[0][0] <= nb_s[10:1];
            hist_r[0][1] <= ns_s[10:1];
        end
    end

endmodule

// File: tb/tb_lct_ghost_filter.sv
// Directed bench for lct_ghost_filter: single track latency, cross-BX and
// same-BX ghosts, promotion, dead-time edges, pass-through, key boundaries,
// freeze, counter saturation and mid-stream reset.
module tb_lct_ghost_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hv, hfap, lv, lfap;
    logic [1:0]  hp, lp;
    logic [6:0]  hnp, lnp;
    logic        filter_en, trig_stop;
    logic [2:0]  dead_time;
    logic        bv, bfa, sv, sfa;
    logic [1:0]  bq, sq;
    logic [6:0]  bkey, skey;
    logic [15:0] lct_cnt, ghost_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_lct = 0;
    int exp_ghost = 0;

    lct_ghost_filter #(.HIST_DEPTH(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .hv(hv), .hp(hp), .hnp(hnp), .hfap(hfap),
        .lv(lv), .lp(lp), .lnp(lnp), .lfap(lfap),
        .filter_en(filter_en), .dead_time(dead_time), .trig_stop(trig_stop),
        .bv(bv), .bq(bq), .bkey(bkey), .bfa(bfa),
        .sv(sv), .sq(sq), .skey(skey), .sfa(sfa),
        .lct_cnt(lct_cnt), .ghost_cnt(ghost_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] trk(input logic [1:0] q, input logic [6:0] k, input logic fa);
        return {1'b1, q, k, fa};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic [10:0] exp);
        chk(tag, {21'd0, bv, bq, bkey, bfa}, {21'd0, exp});
    endtask

    task automatic chk_s(input string tag, input logic [10:0] exp);
        chk(tag, {21'd0, sv, sq, skey, sfa}, {21'd0, exp});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_lct"}, {16'd0, lct_cnt}, exp_lct);
        chk({tag, "_ghost"}, {16'd0, ghost_cnt}, exp_ghost);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hv = 1'b0; hp = 2'd0; hnp = 7'd0; hfap = 1'b0;
        lv = 1'b0; lp = 2'd0; lnp = 7'd0; lfap = 1'b0;
    endtask

    task automatic put_h(input logic [1:0] q, input logic [6:0] k, input logic fa);
        hv = 1'b1; hp = q; hnp = k; hfap = fa;
    endtask

    task automatic put_l(input logic [1:0] q, input logic [6:0] k, input logic fa);
        lv = 1'b1; lp = q; lnp = k; lfap = fa;
    endtask

    task automatic flush();
        idle();
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        filter_en = 1'b1; dead_time = 3'd3; trig_stop = 1'b0;
        idle();
        #2;
        chk_b("rst_b", 11'd0);
        chk_s("rst_s", 11'd0);
        chk_cnt("rst");
        #10 rst_n = 1'b1;
        tick();

        // Single track, 2 clk latency.
        put_h(2'd2, 7'd40, 1'b0); tick();
        chk_b("lat_early", 11'd0);
        idle(); tick();
        chk_b("single_b", trk(2'd2, 7'd40, 1'b0));
        exp_lct = 1; chk_cnt("single");

        // Cross-BX ghost with equal quality, then pass with better quality.
        flush();
        put_h(2'd2, 7'd40, 1'b0); tick();
        put_h(2'd2, 7'd41, 1'b0); tick();
        chk_b("xbx_first", trk(2'd2, 7'd40, 1'b0));
        idle(); tick();
        chk_b("xbx_ghost", 11'd0);
        exp_lct = 2; exp_ghost = 1; chk_cnt("xbx");
        flush();
        put_h(2'd2, 7'd40, 1'b0); tick();
        put_h(2'd3, 7'd41, 1'b0); tick();
        idle(); tick();
        chk_b("xbx_better", trk(2'd3, 7'd41, 1'b0));
        exp_lct = 4; chk_cnt("xbx_better");

        // Dead-time edges.
        dead_time = 3'd2;
        flush();
        put_h(2'd1, 7'd60, 1'b0); tick();
        idle(); tick(); tick();
        put_h(2'd1, 7'd60, 1'b0); tick();
        idle(); tick();
        chk_b("age2_pass", trk(2'd1, 7'd60, 1'b0));
        exp_lct = 6; chk_cnt("age2");
        flush();
        put_h(2'd1, 7'd60, 1'b0); tick();
        idle(); tick();
        put_h(2'd1, 7'd60, 1'b0); tick();
        idle(); tick();
        chk_b("age1_ghost", 11'd0);
        exp_lct = 7; exp_ghost = 2; chk_cnt("age1");
        dead_time = 3'd0;
        flush();
        put_h(2'd1, 7'd60, 1'b0); tick();
        tick();
        chk_b("dt0_first", trk(2'd1, 7'd60, 1'b0));
        idle(); tick();
        chk_b("dt0_second", trk(2'd1, 7'd60, 1'b0));
        exp_lct = 9; chk_cnt("dt0");

        // Same-BX ghost plus promotion.
        dead_time = 3'd3;
        flush();
        put_h(2'd3, 7'd10, 1'b0); tick();
        put_h(2'd1, 7'd10, 1'b0); put_l(2'd1, 7'd11, 1'b0); tick();
        idle(); tick();
        chk_b("both_sup_b", 11'd0);
        chk_s("both_sup_s", 11'd0);
        exp_lct = 10; exp_ghost = 4; chk_cnt("both_sup");
        flush();
        put_h(2'd3, 7'd10, 1'b0); tick();
        put_h(2'd1, 7'd10, 1'b0); put_l(2'd2, 7'd30, 1'b1); tick();
        idle(); tick();
        chk_b("promo_b", trk(2'd2, 7'd30, 1'b1));
        chk_s("promo_s", 11'd0);
        exp_lct = 12; exp_ghost = 5; chk_cnt("promo");

        // Pass-through: no same-BX suppression and no promotion.
        flush();
        filter_en = 1'b0;
        put_h(2'd2, 7'd20, 1'b0); put_l(2'd1, 7'd21, 1'b1); tick();
        idle(); tick();
        chk_b("pass_b", trk(2'd2, 7'd20, 1'b0));
        chk_s("pass_s", trk(2'd1, 7'd21, 1'b1));
        put_l(2'd3, 7'd22, 1'b0); tick();
        idle(); tick();
        chk_b("pass_nopromo_b", 11'd0);
        chk_s("pass_nopromo_s", trk(2'd3, 7'd22, 1'b0));
        exp_lct = 15; chk_cnt("pass");
        filter_en = 1'b1;

        // Keys 0 and 127 never match.
        flush();
        put_h(2'd3, 7'd127, 1'b0); tick();
        put_h(2'd0, 7'd0, 1'b0); tick();
        chk_b("k127", trk(2'd3, 7'd127, 1'b0));
        idle(); tick();
        chk_b("k0_after_127", trk(2'd0, 7'd0, 1'b0));
        flush();
        put_h(2'd1, 7'd0, 1'b0); put_l(2'd1, 7'd127, 1'b0); tick();
        idle(); tick();
        chk_s("k0_k127_same", trk(2'd1, 7'd127, 1'b0));
        exp_lct = 19; chk_cnt("keys");

        // Freeze for 5 clk: outputs zero, counters and history held.
        flush();
        put_h(2'd2, 7'd70, 1'b0); tick();
        idle(); tick();
        chk_b("pre_frz", trk(2'd2, 7'd70, 1'b0));
        exp_lct = 20;
        trig_stop = 1'b1;
        put_h(2'd1, 7'd99, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_b("frz_b", 11'd0);
            chk_cnt("frz");
        end
        trig_stop = 1'b0;
        idle(); put_h(2'd1, 7'd71, 1'b0); tick();
        chk_b("post_frz", trk(2'd1, 7'd99, 1'b0));
        idle(); tick();
        chk_b("frz_hist_held", 11'd0);
        exp_lct = 21; exp_ghost = 6; chk_cnt("post_frz");

        // Counter saturation: one emitted and one same-BX ghost per clk.
        dead_time = 3'd0;
        flush();
        put_h(2'd3, 7'd50, 1'b0); put_l(2'd0, 7'd51, 1'b0);
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        idle(); tick(); tick(); tick();
        chk("sat_ghost", {16'd0, ghost_cnt}, 32'h0000FFFF);
        chk("sat_lct", {16'd0, lct_cnt}, 32'h0000FFFF);
        put_h(2'd3, 7'd50, 1'b0); put_l(2'd0, 7'd51, 1'b0);
        tick(); tick(); tick();
        idle(); tick(); tick();
        chk("sat_ghost_hold", {16'd0, ghost_cnt}, 32'h0000FFFF);

        // Reset mid-stream clears outputs, counters and history.
        dead_time = 3'd3;
        flush();
        put_h(2'd3, 7'd80, 1'b0); tick();
        idle(); tick();
        chk_b("pre_rst", trk(2'd3, 7'd80, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk_b("rst_async_b", 11'd0);
        exp_lct = 0; exp_ghost = 0; chk_cnt("rst_async");
        tick();
        #3 rst_n = 1'b1;
        put_h(2'd1, 7'd80, 1'b0); tick();
        idle(); tick();
        chk_b("post_rst_pass", trk(2'd1, 7'd80, 1'b0));
        exp_lct = 1; chk_cnt("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
